// File: rtl/sha256_pkg.sv
// sha256_pkg: shared FSM states, sizing constants, IVs and round constants
package sha256_pkg;
  localparam int NUM_ROUNDS = 64;
  localparam int MSG_WORDS = 16;
  localparam int CNT_W = $clog2(NUM_ROUNDS);
  typedef enum logic [2:0] {IDLE, PREP, MSG, EXP, UPD, DONE} state_t;
  localparam logic [31:0] IV_256 [8] = '{
    32'h6a09e667, 32'hbb67ae85, 32'h3c6ef372, 32'ha54ff53a,
    32'h510e527f, 32'h9b05688c, 32'h1f83d9ab, 32'h5be0cd19};
  localparam logic [31:0] IV_224 [8] = '{
    32'hc1059ed8, 32'h367cd507, 32'h3070dd17, 32'hf70e5939,
    32'hffc00b31, 32'h68581511, 32'h64f98fa7, 32'hbefa4fa4};
  localparam logic [31:0] K_TABLE [64] = '{
    32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
    32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3, 32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
    32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
    32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
    32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13, 32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
    32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
    32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
    32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208, 32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2};
endpackage

// File: rtl/sha256_round_cnt.sv
// sha256_round_cnt: round index counter with end-of-message and last-round flags
module sha256_round_cnt
  import sha256_pkg::*;
(
  input  logic CLK,
  input  logic RST,
  input  logic clr,
  input  logic en,
  output logic [CNT_W-1:0] q,
  output logic at_msg,
  output logic at_last
);
  always_ff @(posedge CLK or negedge RST)
    if (!RST) q <= '0;
    else if (clr) q <= '0;
    else if (en) q <= q + 1'b1;
  always_comb begin
    at_msg = q == CNT_W'(MSG_WORDS - 1);
    at_last = q == CNT_W'(NUM_ROUNDS - 1);
  end
endmodule

// File: rtl/sha256_round_ctrl.sv
// sha256_round_ctrl: SHA-256 compression round sequencer (load/round/update strobes)
// Define SHA224_EN to add mode_224/iv_sel for SHA-224 IV selection.
module sha256_round_ctrl
  import sha256_pkg::*;
(
  input  logic CLK,
  input  logic RST,
  input  logic init,
  input  logic next,
  input  logic word_valid,
`ifdef SHA224_EN
  input  logic mode_224,
  output logic iv_sel,
`endif
  output logic word_ready,
  output logic h_init,
  output logic wv_init,
  output logic wv_en,
  output logic w_sel,
  output logic [CNT_W-1:0] round_idx,
  output logic h_update,
  output logic busy,
  output logic digest_valid
);
  state_t state, state_nxt;
  logic at_msg, at_last;
  always_ff @(posedge CLK or negedge RST)
    if (!RST) state <= IDLE;
    else state <= state_nxt;
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: state_nxt = (init || next) ? PREP : IDLE;
      PREP: state_nxt = MSG;
      MSG: state_nxt = (word_valid && at_msg) ? EXP : MSG;
      EXP: state_nxt = at_last ? UPD : EXP;
      UPD: state_nxt = DONE;
      default: state_nxt = IDLE;
    endcase
  end
  // h_init is gated by RST so an init held during reset cannot show through
  always_comb begin
    h_init = RST && state == IDLE && init;
    wv_init = state == PREP;
    word_ready = state == MSG && word_valid;
    wv_en = word_ready || state == EXP;
    w_sel = state == EXP;
    h_update = state == UPD;
    busy = state != IDLE;
    digest_valid = state == DONE;
  end
`ifdef SHA224_EN
  always_ff @(posedge CLK or negedge RST)
    if (!RST) iv_sel <= 1'b0;
    else if (h_init) iv_sel <= mode_224;
`endif
  sha256_round_cnt u_cnt (
    .CLK(CLK),
    .RST(RST),
    .clr(wv_init),
    .en(wv_en),
    .q(round_idx),
    .at_msg(at_msg),
    .at_last(at_last)
  );
endmodule

// File: tb/tb_sha256_round_ctrl.sv
// tb_sha256_round_ctrl: vector table of block scenarios checked against edge-indexed expectations
module tb_sha256_round_ctrl;
  logic CLK = 1'b0;
  logic RST = 1'b0;
  logic init = 1'b0, next = 1'b0, word_valid = 1'b0;
  logic word_ready, h_init, wv_init, wv_en, w_sel, h_update, busy, digest_valid;
  logic [5:0] round_idx;
`ifdef SHA224_EN
  logic mode_224 = 1'b0;
  logic iv_sel;
`endif
  int checks = 0;
  int errors = 0;
  int exp_q[$];
  typedef struct {
    logic ini;
    logic nxt;
    int stall_at;
    int stall_len;
    logic pulse;
    logic exp_h_init;
    int exp_dv;
  } vec_t;
  vec_t vecs[6];

  sha256_round_ctrl dut (
    .CLK(CLK),
    .RST(RST),
    .init(init),
    .next(next),
    .word_valid(word_valid),
`ifdef SHA224_EN
    .mode_224(mode_224),
    .iv_sel(iv_sel),
`endif
    .word_ready(word_ready),
    .h_init(h_init),
    .wv_init(wv_init),
    .wv_en(wv_en),
    .w_sel(w_sel),
    .round_idx(round_idx),
    .h_update(h_update),
    .busy(busy),
    .digest_valid(digest_valid)
  );

  always #5 CLK = ~CLK;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // k counts rising edges after the one that samples init/next
  task automatic run_block(input vec_t v);
    int r, wv, hu, dv, bad, exp_dv;
    logic stall;
    r = 0; wv = 0; hu = -1; dv = -1; bad = 0;
    @(negedge CLK);
    init = v.ini; next = v.nxt; word_valid = 1'b1;
    #1;
    check("h_init_start", h_init, v.exp_h_init);
    check("busy_idle", busy, 0);
    exp_q.push_back(v.exp_dv);
    @(negedge CLK);
    init = 1'b0; next = 1'b0;
    #1;
    check("prep", {wv_init, busy, word_ready, wv_en, h_init}, 5'b11000);
    for (int k = 1; k <= 200 && dv < 0; k++) begin
      @(negedge CLK);
      stall = k > v.stall_at && k <= v.stall_at + v.stall_len;
      word_valid = !stall;
      init = v.pulse && k == 30;
      #1;
      if (k <= 64 + v.stall_len) begin
        if (round_idx !== 6'(r) || wv_en !== !stall || w_sel !== (r >= 16) ||
            word_ready !== (r < 16 && !stall) || {h_init, h_update, digest_valid, wv_init} !== 4'b0 ||
            busy !== 1'b1) bad++;
        wv += int'(wv_en);
        if (!stall) r++;
      end
      if (h_update === 1'b1) hu = k;
      if (digest_valid === 1'b1) dv = k;
    end
    init = 1'b0;
    word_valid = 1'b1;
    check("round_seq", bad, 0);
    check("wv_en_count", wv, 64);
    check("h_update_edge", hu, v.exp_dv - 1);
    exp_dv = exp_q.pop_front();
    check("digest_edge", dv, exp_dv);
    @(negedge CLK);
    #1;
    check("idle_after", {busy, digest_valid}, 2'b00);
  endtask

  initial begin
    int seen;
    vecs[0] = '{1'b1, 1'b0, 0, 0, 1'b0, 1'b1, 66};
    vecs[1] = '{1'b1, 1'b0, 5, 3, 1'b0, 1'b1, 69};
    vecs[2] = '{1'b0, 1'b1, 0, 0, 1'b0, 1'b0, 66};
    vecs[3] = '{1'b1, 1'b1, 0, 0, 1'b1, 1'b1, 66};
    vecs[4] = '{1'b0, 1'b1, 15, 2, 1'b0, 1'b0, 68};
    vecs[5] = '{1'b1, 1'b0, 0, 1, 1'b0, 1'b1, 67};
    #12;
    check("reset_state", {h_init, wv_init, wv_en, w_sel, word_ready, h_update, busy, digest_valid, round_idx}, 0);
`ifdef SHA224_EN
    check("reset_iv_sel", iv_sel, 0);
`endif
    @(negedge CLK);
    RST = 1'b1;
    for (int i = 0; i < 6; i++) run_block(vecs[i]);
    @(negedge CLK);
    init = 1'b1; word_valid = 1'b1;
    @(negedge CLK);
    init = 1'b0;
    repeat (31) @(negedge CLK);
    #1;
    check("round_30", round_idx, 30);
    RST = 1'b0;
    #1;
    check("reset_async", {h_init, wv_init, wv_en, w_sel, word_ready, h_update, busy, digest_valid, round_idx}, 0);
    @(negedge CLK);
    RST = 1'b1;
    seen = 0;
    repeat (80) begin
      @(negedge CLK);
      #1;
      if (busy !== 1'b0 || digest_valid !== 1'b0) seen++;
    end
    check("post_reset_idle", seen, 0);
`ifdef SHA224_EN
    mode_224 = 1'b1;
    run_block(vecs[0]);
    check("iv_sel_init224", iv_sel, 1);
    mode_224 = 1'b0;
    run_block(vecs[2]);
    check("iv_sel_next_held", iv_sel, 1);
    run_block(vecs[0]);
    check("iv_sel_init256", iv_sel, 0);
`endif
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
